mrv32_lsu: RTL and testbench
============================

MRV32_LSU -- requirements
Module: mrv32_lsu

Interface
REQ-001 Parameter AW, default mrv32_pkg::ADDR_WIDTH (20), memory byte-address width.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 req_valid  input  1  core presents a load/store request.
REQ-005 req_ready  output  1  LSU can accept a request this cycle.
REQ-006 req_store  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I funct3 width/sign code.
REQ-008 req_addr  input  XLEN  effective byte address.
REQ-009 req_wdata  input  XLEN  store data (rs2).
REQ-010 req_rd  input  REGADDR  load destination register.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  XLEN  formatted load data; 0 for stores and errors.
REQ-013 rsp_rd  output  REGADDR  latched req_rd; 0 for stores.
REQ-014 rsp_err  output  1  misaligned access or illegal funct3.
REQ-015 mem_req  output  1  memory request valid.
REQ-016 mem_gnt  input  1  memory accepts mem_req this cycle.
REQ-017 mem_we  output  1  write enable.
REQ-018 mem_addr  output  AW  word-aligned byte address, bits [1:0] = 0.
REQ-019 mem_wstrb  output  4  byte enables (WSTRB_* shifted by lane).
REQ-020 mem_wdata  output  XLEN  lane-replicated store data.
REQ-021 mem_rvalid / mem_rdata  input  1 / XLEN  read return, one pulse per read.

Function
REQ-022 FSM states IDLE, REQ, WAIT, RESP; req_ready=1 only in IDLE.
REQ-023 IDLE & req_valid: latch all req_* fields; legal+aligned -> REQ; otherwise -> RESP with rsp_err=1, no memory access.
REQ-024 Legal: loads funct3 000,001,010,100,101; stores 000,001,010; all else illegal.
REQ-025 Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0; bytes never misaligned.
REQ-026 REQ: mem_req=1, mem_we/mem_addr/mem_wstrb/mem_wdata held stable until mem_gnt; stays in REQ indefinitely without gnt.
REQ-027 REQ & mem_gnt: store -> RESP; load -> WAIT.
REQ-028 WAIT: on mem_rvalid capture formatted data -> RESP; mem_rvalid outside WAIT ignored.
REQ-029 RESP: rsp_valid=1 exactly one cycle, then IDLE; no response backpressure.
REQ-030 Latency, accept at edge N, zero-wait memory: store rsp_valid in cycle N+2, load in N+3 (rvalid the cycle after gnt); error rsp in N+1.
REQ-031 mem_addr = {req_addr[AW-1:2],2'b00}; address bits >= AW ignored.
REQ-032 Stores: SB wstrb=0001<<addr[1:0], wdata={4{wdata[7:0]}}; SH wstrb=0011<<addr[1:0], wdata={2{wdata[15:0]}}; SW 1111, wdata as-is.
REQ-033 Loads: LB/LBU take byte lane addr[1:0], sign-/zero-extend; LH/LHU take halfword addr[1], sign-/zero-extend; LW full word.
REQ-034 Outside REQ: mem_req=0, mem_we=0, mem_wstrb=0.
REQ-035 rsp_rdata, rsp_rd, rsp_err valid only while rsp_valid=1; 0 otherwise.

Reset
REQ-036 rst=1: state IDLE; all outputs 0 except req_ready=1 from first cycle after rst deasserts.
REQ-037 rst mid-transaction abandons it: no rsp_valid, mem_req drops next cycle, late mem_rvalid ignored.

Verification
REQ-038 SB addr=0x00003, wdata=0x000000A5, gnt immediate -> mem_wstrb=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x00000, rsp_valid at N+2, rsp_err=0.
REQ-039 LB addr=0x00102, mem_rdata=0x12C34567 -> rsp_rdata=0xFFFFFFC3; LBU same -> 0x000000C3; LHU addr=0x00102 -> 0x000012C3.
REQ-040 LW addr=0x00006 -> rsp_err=1, rsp_rdata=0, mem_req never asserted, rsp_valid at N+1.
REQ-041 SW with mem_gnt withheld 5 cycles -> mem_req/addr/wdata/wstrb stable all 5 cycles, req_ready=0, single rsp_valid 1 cycle after gnt.
REQ-042 LW issued, rst pulsed in WAIT, then mem_rvalid -> no rsp_valid, req_ready=1 after reset, next LW completes normally.
REQ-043 Load funct3=011 -> rsp_err=1, no memory access; back-to-back requests each see req_ready low until prior rsp_valid done.

Source files
------------

// File: rtl/mrv32_lsu_if.sv
// Shared MRV32 constants and the LSU bundle. The bundle carries the core-side
// request/response handshake and the memory-side bus. The LSU uses the slave
// view. The master view belongs to whoever drives the core and memory side.

package mrv32_pkg;
  localparam int XLEN       = 32;
  localparam int REGADDR    = 5;
  localparam int ADDR_WIDTH = 20;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] WSTRB_B = 4'b0001;
  localparam logic [3:0] WSTRB_H = 4'b0011;
  localparam logic [3:0] WSTRB_W = 4'b1111;
endpackage

interface mrv32_lsu_if #(parameter int AW = mrv32_pkg::ADDR_WIDTH);
  import mrv32_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic               req_store;
  logic [2:0]         req_funct3;
  logic [XLEN-1:0]    req_addr;
  logic [XLEN-1:0]    req_wdata;
  logic [REGADDR-1:0] req_rd;

  logic               rsp_valid;
  logic [XLEN-1:0]    rsp_rdata;
  logic [REGADDR-1:0] rsp_rd;
  logic               rsp_err;

  logic               mem_req;
  logic               mem_gnt;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [3:0]         mem_wstrb;
  logic [XLEN-1:0]    mem_wdata;
  logic               mem_rvalid;
  logic [XLEN-1:0]    mem_rdata;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_err,
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_err,
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );
endinterface

// File: rtl/mrv32_lsu.sv
// MRV32 load/store unit. It accepts one request at a time, rejects illegal or
// misaligned accesses without touching memory, and places stores on the correct
// byte lanes. It also extracts and extends load data. It sends exactly one
// response pulse per accepted request.

module mrv32_lsu
  import mrv32_pkg::*;
#(
  parameter int AW = ADDR_WIDTH
) (
  input logic        clk,
  input logic        rst,
  mrv32_lsu_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t             state_q;
  logic               reqReady_q;
  logic               store_q;
  logic [2:0]         funct3_q;
  logic [1:0]         lane_q;
  logic [REGADDR-1:0] rd_q;

  logic               memReq_q;
  logic               memWe_q;
  logic [AW-1:0]      memAddr_q;
  logic [3:0]         memWstrb_q;
  logic [XLEN-1:0]    memWdata_q;

  logic               rspValid_q;
  logic [XLEN-1:0]    rspRdata_q;
  logic [REGADDR-1:0] rspRd_q;
  logic               rspErr_q;

  logic               reqLegal;
  logic               reqAligned;
  logic [3:0]         storeStrb;
  logic [XLEN-1:0]    storeData;
  logic [7:0]         loadByte;
  logic [15:0]        loadHalf;
  logic [XLEN-1:0]    loadData;

  // Address bits above the memory width are intentionally dropped.
  logic unusedAddrBits;
  assign unusedAddrBits = ^bus.req_addr[XLEN-1:AW];

  // Decode the incoming request: legality, alignment, and lane-placed store data.
  always_comb begin
    reqLegal   = 1'b0;
    reqAligned = 1'b1;
    storeStrb  = '0;
    storeData  = '0;
    if (bus.req_store) begin
      reqLegal = (bus.req_funct3 == F3_B) || (bus.req_funct3 == F3_H) ||
                 (bus.req_funct3 == F3_W);
    end else begin
      reqLegal = (bus.req_funct3 == F3_B)  || (bus.req_funct3 == F3_H)  ||
                 (bus.req_funct3 == F3_W)  || (bus.req_funct3 == F3_BU) ||
                 (bus.req_funct3 == F3_HU);
    end
    case (bus.req_funct3[1:0])
      2'b00: begin
        storeStrb = WSTRB_B << bus.req_addr[1:0];
        storeData = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        reqAligned = ~bus.req_addr[0];
        storeStrb  = WSTRB_H << bus.req_addr[1:0];
        storeData  = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        reqAligned = (bus.req_addr[1:0] == 2'b00);
        storeStrb  = WSTRB_W;
        storeData  = bus.req_wdata;
      end
    endcase
  end

  // Pick the addressed byte or halfword out of the returned word and extend it.
  always_comb begin
    loadByte = bus.mem_rdata[{lane_q, 3'b000} +: 8];
    loadHalf = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3_q)
      F3_B:    loadData = {{24{loadByte[7]}}, loadByte};
      F3_BU:   loadData = {24'd0, loadByte};
      F3_H:    loadData = {{16{loadHalf[15]}}, loadHalf};
      F3_HU:   loadData = {16'd0, loadHalf};
      default: loadData = bus.mem_rdata;
    endcase
  end

  // Transaction FSM. Every output comes from a register so the bus sees no glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      reqReady_q <= 1'b0;
      store_q    <= 1'b0;
      funct3_q   <= '0;
      lane_q     <= '0;
      rd_q       <= '0;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWstrb_q <= '0;
      memWdata_q <= '0;
      rspValid_q <= 1'b0;
      rspRdata_q <= '0;
      rspRd_q    <= '0;
      rspErr_q   <= 1'b0;
    end else begin
      rspValid_q <= 1'b0;
      rspRdata_q <= '0;
      rspRd_q    <= '0;
      rspErr_q   <= 1'b0;
      reqReady_q <= 1'b0;
      case (state_q)
        IDLE: begin
          reqReady_q <= 1'b1;
          if (reqReady_q && bus.req_valid) begin
            reqReady_q <= 1'b0;
            store_q    <= bus.req_store;
            funct3_q   <= bus.req_funct3;
            lane_q     <= bus.req_addr[1:0];
            rd_q       <= bus.req_rd;
            if (reqLegal && reqAligned) begin
              state_q    <= REQ;
              memReq_q   <= 1'b1;
              memWe_q    <= bus.req_store;
              memAddr_q  <= {bus.req_addr[AW-1:2], 2'b00};
              memWstrb_q <= bus.req_store ? storeStrb : 4'b0000;
              memWdata_q <= bus.req_store ? storeData : '0;
            end else begin
              state_q    <= RESP;
              rspValid_q <= 1'b1;
              rspErr_q   <= 1'b1;
              rspRd_q    <= bus.req_store ? '0 : bus.req_rd;
            end
          end
        end
        REQ: begin
          if (bus.mem_gnt) begin
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memWstrb_q <= '0;
            if (store_q) begin
              state_q    <= RESP;
              rspValid_q <= 1'b1;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            state_q    <= RESP;
            rspValid_q <= 1'b1;
            rspRdata_q <= loadData;
            rspRd_q    <= rd_q;
          end
        end
        RESP: begin
          state_q    <= IDLE;
          reqReady_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = reqReady_q;
  assign bus.rsp_valid = rspValid_q;
  assign bus.rsp_rdata = rspRdata_q;
  assign bus.rsp_rd    = rspRd_q;
  assign bus.rsp_err   = rspErr_q;
  assign bus.mem_req   = memReq_q;
  assign bus.mem_we    = memWe_q;
  assign bus.mem_addr  = memAddr_q;
  assign bus.mem_wstrb = memWstrb_q;
  assign bus.mem_wdata = memWdata_q;

endmodule

// File: tb/tb_mrv32_lsu.sv
// Self-checking bench for mrv32_lsu. Directed scenarios are followed by
// randomized transactions. Each result is compared with an arithmetic
// reference model of the load/store rules.

module tb_mrv32_lsu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mrv32_lsu_if bus ();

  mrv32_lsu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10-unit clock. Stimulus changes and sampling both happen on the falling edge.
  always #5 clk = ~clk;

  // Hard stop in case anything stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before the summary");
    $fatal(1, "[TB] watchdog");
  end

  // One comparison: count it, and report any difference.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model. It works from access size in bytes and lane arithmetic.
  task automatic modelTxn(input bit st, input bit [2:0] f3, input bit [31:0] a,
                          input bit [31:0] wd, input bit [31:0] rdIn, input bit [4:0] rd,
                          output bit err, output bit [3:0] strb, output bit [31:0] mwd,
                          output bit [19:0] maddr, output bit [31:0] rdat, output bit [4:0] rrd);
    int unsigned lane, size, v;
    bit legal;
    lane  = a % 4;
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 32'd1 << f3[1:0];
    err   = !legal || ((a % size) != 0);
    maddr = 20'((a % 32'h100000) / 4 * 4);
    rrd   = st ? 5'd0 : rd;
    strb  = 4'd0;
    mwd   = 32'd0;
    rdat  = 32'd0;
    if (!err && st) begin
      strb = 4'(((32'd1 << size) - 1) << lane);
      if (size == 1)      mwd = (wd & 32'hFF) * 32'h01010101;
      else if (size == 2) mwd = (wd & 32'hFFFF) * 32'h00010001;
      else                mwd = wd;
    end
    if (!err && !st) begin
      v = rdIn >> (8 * lane);
      if (size < 4) begin
        v = v & ((32'd1 << (8 * size)) - 1);
        if (f3 < 3'd4 && v >= (32'd1 << (8 * size - 1))) v = v - (32'd1 << (8 * size));
      end
      rdat = v;
    end
  endtask

  // Run one full transaction. The model supplies every expected value and each cycle is checked.
  task automatic applyStimulus(input string tag, input bit st, input bit [2:0] f3,
                               input bit [31:0] a, input bit [31:0] wd, input bit [4:0] rd,
                               input bit [31:0] rdIn, input int gntDelay, input int rvDelay);
    bit        eErr;
    bit [3:0]  eStrb;
    bit [31:0] eWdata, eRdata;
    bit [19:0] eAddr;
    bit [4:0]  eRd;
    modelTxn(st, f3, a, wd, rdIn, rd, eErr, eStrb, eWdata, eAddr, eRdata, eRd);

    for (int i = 0; i < 20 && bus.req_ready !== 1'b1; i++) @(negedge clk);
    checkOutput({tag, ":ready"}, 32'(bus.req_ready), 32'd1);

    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_rd     = rd;
    @(negedge clk);
    // Scramble request fields so the bench would notice if the DUT failed to latch them.
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    bus.req_rd     = 5'($urandom);

    if (eErr) begin
      checkOutput({tag, ":errValid"}, 32'(bus.rsp_valid), 32'd1);
      checkOutput({tag, ":errFlag"}, 32'(bus.rsp_err), 32'd1);
      checkOutput({tag, ":errRdata"}, bus.rsp_rdata, 32'd0);
      checkOutput({tag, ":errRd"}, 32'(bus.rsp_rd), 32'(eRd));
      checkOutput({tag, ":errMemReq"}, 32'(bus.mem_req), 32'd0);
      checkOutput({tag, ":errReady"}, 32'(bus.req_ready), 32'd0);
    end else begin
      for (int k = 0; k <= gntDelay; k++) begin
        checkOutput({tag, ":memReq"}, 32'(bus.mem_req), 32'd1);
        checkOutput({tag, ":memWe"}, 32'(bus.mem_we), 32'(st));
        checkOutput({tag, ":memAddr"}, 32'(bus.mem_addr), 32'(eAddr));
        checkOutput({tag, ":memWstrb"}, 32'(bus.mem_wstrb), 32'(eStrb));
        checkOutput({tag, ":memWdata"}, bus.mem_wdata, eWdata);
        checkOutput({tag, ":busyReady"}, 32'(bus.req_ready), 32'd0);
        checkOutput({tag, ":earlyRsp"}, 32'(bus.rsp_valid), 32'd0);
        bus.mem_gnt    = (k == gntDelay);
        bus.mem_rvalid = 1'($urandom);
        bus.mem_rdata  = $urandom;
        @(negedge clk);
      end
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      if (!st) begin
        for (int j = 0; j <= rvDelay; j++) begin
          checkOutput({tag, ":waitRsp"}, 32'(bus.rsp_valid), 32'd0);
          checkOutput({tag, ":waitMemReq"}, 32'(bus.mem_req), 32'd0);
          checkOutput({tag, ":waitWstrb"}, 32'(bus.mem_wstrb), 32'd0);
          bus.mem_rvalid = (j == rvDelay);
          bus.mem_rdata  = (j == rvDelay) ? rdIn : $urandom;
          @(negedge clk);
        end
        bus.mem_rvalid = 1'b0;
      end
      checkOutput({tag, ":rspValid"}, 32'(bus.rsp_valid), 32'd1);
      checkOutput({tag, ":rspErr"}, 32'(bus.rsp_err), 32'd0);
      checkOutput({tag, ":rspRdata"}, bus.rsp_rdata, eRdata);
      checkOutput({tag, ":rspRd"}, 32'(bus.rsp_rd), 32'(eRd));
      checkOutput({tag, ":rspMemReq"}, 32'(bus.mem_req), 32'd0);
      checkOutput({tag, ":rspReady"}, 32'(bus.req_ready), 32'd0);
    end

    @(negedge clk);
    checkOutput({tag, ":pulseEnd"}, 32'(bus.rsp_valid), 32'd0);
    checkOutput({tag, ":idleRdata"}, bus.rsp_rdata, 32'd0);
    checkOutput({tag, ":idleErr"}, 32'(bus.rsp_err), 32'd0);
    checkOutput({tag, ":idleRd"}, 32'(bus.rsp_rd), 32'd0);
    checkOutput({tag, ":idleReady"}, 32'(bus.req_ready), 32'd1);
  endtask

  // Main sequence: reset, directed scenarios, randomized traffic, then the summary.
  initial begin
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.req_rd     = 5'd0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'd0;

    // While reset is held every output is zero.
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst:ready", 32'(bus.req_ready), 32'd0);
    checkOutput("rst:rspValid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rst:rspRdata", bus.rsp_rdata, 32'd0);
    checkOutput("rst:rspRd", 32'(bus.rsp_rd), 32'd0);
    checkOutput("rst:rspErr", 32'(bus.rsp_err), 32'd0);
    checkOutput("rst:memReq", 32'(bus.mem_req), 32'd0);
    checkOutput("rst:memWe", 32'(bus.mem_we), 32'd0);
    checkOutput("rst:memAddr", 32'(bus.mem_addr), 32'd0);
    checkOutput("rst:memWstrb", 32'(bus.mem_wstrb), 32'd0);
    checkOutput("rst:memWdata", bus.mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postRst:ready", 32'(bus.req_ready), 32'd1);

    // Store byte to lane 3 with an immediate grant.
    applyStimulus("sbLane3", 1'b1, 3'b000, 32'h00003, 32'h000000A5, 5'd9, 32'd0, 0, 0);
    // Byte and halfword loads from an upper lane, with sign and zero extension.
    applyStimulus("lbSigned", 1'b0, 3'b000, 32'h00102, 32'd0, 5'd3, 32'h12C34567, 0, 0);
    applyStimulus("lbuZero", 1'b0, 3'b100, 32'h00102, 32'd0, 5'd4, 32'h12C34567, 0, 0);
    applyStimulus("lhuUpper", 1'b0, 3'b101, 32'h00102, 32'd0, 5'd5, 32'h12C34567, 0, 0);
    applyStimulus("lhSigned", 1'b0, 3'b001, 32'h00102, 32'd0, 5'd6, 32'h92C34567, 1, 2);
    // A misaligned word load is rejected without a memory access.
    applyStimulus("lwMisalign", 1'b0, 3'b010, 32'h00006, 32'd0, 5'd7, 32'd0, 0, 0);
    // A store word that waits 5 cycles for its grant keeps the bus stable.
    applyStimulus("swStall", 1'b1, 3'b010, 32'hFFF4A5C8, 32'hDEADBEEF, 5'd1, 32'd0, 5, 0);

    // Reset while a load is waiting for data abandons the load.
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h00010;
    bus.req_rd     = 5'd7;
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkOutput("abort:memReq", 32'(bus.mem_req), 32'd1);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    checkOutput("abort:inWait", 32'(bus.mem_req), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst            = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFEF00D;
    checkOutput("abort:rstRsp", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    checkOutput("abort:lateRvalid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("abort:readyBack", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("abort:quiet", 32'(bus.rsp_valid), 32'd0);
    end
    applyStimulus("lwAfterRst", 1'b0, 3'b010, 32'h00010, 32'd0, 5'd7, 32'h01234567, 0, 0);

    // An illegal load funct3 followed by back-to-back requests.
    applyStimulus("ld011", 1'b0, 3'b011, 32'h00020, 32'd0, 5'd2, 32'd0, 0, 0);
    applyStimulus("b2bSh", 1'b1, 3'b001, 32'h00022, 32'h0000BEEF, 5'd0, 32'd0, 0, 0);
    applyStimulus("b2bSt110", 1'b1, 3'b110, 32'h00024, 32'h11111111, 5'd0, 32'd0, 0, 0);
    applyStimulus("b2bLbu", 1'b0, 3'b100, 32'h00021, 32'd0, 5'd31, 32'hA1B2C3D4, 2, 1);

    // Randomized traffic. Half the addresses are word-aligned so legal accesses are common.
    for (int n = 0; n < 40; n++) begin
      bit [31:0] ra;
      ra = $urandom;
      if ($urandom_range(0, 1) == 0) ra[1:0] = 2'b00;
      applyStimulus("rand", 1'($urandom), 3'($urandom), ra, $urandom, 5'($urandom),
                    $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
